// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// - Load-use hazard between ID and EX: one-cycle PC/IF hold plus an ID/EX bubble.
// - Multi-cycle data-memory access in MEM: holds the whole pipeline until dmem_ack.
// - Taken branch resolved in MEM: flushes IF/ID, ID/EX and EX/MEM.
// - MEM_WAIT without ack for MEM_TIMEOUT cycles: sticky ERR, left only through rst.
// Optional feature macro: PIPE_HAZ_PERF_CNT_EN enables the three saturating
// performance counters. Without it the counter ports are tied to 0.
//
// Handshake: dmem_req stays high from the first cycle a load/store sits in MEM
// until the cycle dmem_ack is seen. dmem_ack only counts while dmem_req is high.
// The access completes in the ack cycle, so the pipeline advances in that cycle.
module pipeline_hazard_ctrl #(
  parameter int REG_NUM_W   = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic [REG_NUM_W-1:0] id_rs,
  input  logic [REG_NUM_W-1:0] id_rt,
  input  logic                 ex_is_load,
  input  logic                 ex_rg_wr_en,
  input  logic [REG_NUM_W-1:0] ex_wr_rg,
  input  logic                 mem_is_load,
  input  logic                 mem_is_store,
  input  logic                 mem_pc_wr_en,
  input  logic                 dmem_ack,
  output logic                 pc_stall,
  output logic                 if_stall,
  output logic                 id_stall,
  output logic                 ex_stall,
  output logic                 if_flush,
  output logic                 ex_flush,
  output logic                 mem_flush,
  output logic                 dmem_req,
  output logic                 mem_timeout_err,
  output logic [1:0]           state_o,
  output logic [CNT_W-1:0]     load_use_cnt,
  output logic [CNT_W-1:0]     mem_wait_cnt,
  output logic [CNT_W-1:0]     br_flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  state_t          state;
  state_t          stateNext;
  state_t          curState;
  logic [TO_W-1:0] toCnt;
  logic [TO_W-1:0] toCntNext;
  logic            errReg;
  logic            errSet;
  logic            memAcc;
  logic            luHaz;
  logic            memStallRun;

  assign memAcc      = mem_is_load | mem_is_store;
  assign memStallRun = memAcc & ~dmem_ack;
  assign luHaz       = id_valid & ex_is_load & ex_rg_wr_en & (ex_wr_rg != '0) &
                       ((id_uses_rs & (id_rs == ex_wr_rg)) |
                        (id_uses_rt & (id_rt == ex_wr_rg)));

  // Outputs are decoded as if in RUN while rst is held.
  always_comb curState = rst ? RUN : state;

  assign state_o         = curState;
  assign mem_timeout_err = errReg;

  // Next-state and Mealy outputs; memory access beats branch beats load-use.
  always_comb begin
    stateNext = curState;
    toCntNext = toCnt;
    errSet    = 1'b0;
    pc_stall  = 1'b0;
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    if_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    dmem_req  = 1'b0;
    case (curState)
      RUN: begin
        dmem_req = memAcc;
        if (memStallRun) begin
          pc_stall  = 1'b1;
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_stall  = 1'b1;
          stateNext = MEM_WAIT;
          toCntNext = TO_W'(1);
        end else if (mem_pc_wr_en) begin
          // PC is left running so it loads the branch target.
          if_flush  = 1'b1;
          ex_flush  = 1'b1;
          mem_flush = 1'b1;
        end else if (luHaz) begin
          // Hold PC and IF/ID, insert a bubble into ID/EX; the load moves on.
          pc_stall = 1'b1;
          if_stall = 1'b1;
          ex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        pc_stall = ~dmem_ack;
        if_stall = ~dmem_ack;
        id_stall = ~dmem_ack;
        ex_stall = ~dmem_ack;
        if (dmem_ack) begin
          stateNext = RUN;
          toCntNext = '0;
        end else if (toCnt == TO_W'(MEM_TIMEOUT)) begin
          stateNext = ERR;
          errSet    = 1'b1;
        end else begin
          toCntNext = toCnt + TO_W'(1);
        end
      end
      ERR: begin
        pc_stall = 1'b1;
        if_stall = 1'b1;
        id_stall = 1'b1;
        ex_stall = 1'b1;
      end
      default: begin
        stateNext = RUN;
        toCntNext = '0;
      end
    endcase
  end

  // State, timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      toCnt  <= '0;
      errReg <= 1'b0;
    end else begin
      state <= stateNext;
      toCnt <= toCntNext;
      if (errSet) errReg <= 1'b1;
    end
  end

`ifdef PIPE_HAZ_PERF_CNT_EN
  logic             luEvt;
  logic             brEvt;
  logic             mwEvt;
  logic [CNT_W-1:0] luCnt;
  logic [CNT_W-1:0] mwCnt;
  logic [CNT_W-1:0] brCnt;

  assign luEvt = (curState == RUN) & ~memStallRun & ~mem_pc_wr_en & luHaz;
  assign brEvt = (curState == RUN) & ~memStallRun & mem_pc_wr_en;
  assign mwEvt = (curState == MEM_WAIT) & ~dmem_ack;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      luCnt <= '0;
      mwCnt <= '0;
      brCnt <= '0;
    end else begin
      if (luEvt && (luCnt != '1)) luCnt <= luCnt + CNT_W'(1);
      if (mwEvt && (mwCnt != '1)) mwCnt <= mwCnt + CNT_W'(1);
      if (brEvt && (brCnt != '1)) brCnt <= brCnt + CNT_W'(1);
    end
  end

  assign load_use_cnt = luCnt;
  assign mem_wait_cnt = mwCnt;
  assign br_flush_cnt = brCnt;
`else
  assign load_use_cnt = '0;
  assign mem_wait_cnt = '0;
  assign br_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, hand-written multi-cycle
// sequences, then randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int RW = 5;
  localparam int TO = 4;
  localparam int CW = 32;
  localparam int W  = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_uses_rs, id_uses_rt;
  logic [RW-1:0] id_rs, id_rt, ex_wr_rg;
  logic          ex_is_load, ex_rg_wr_en;
  logic          mem_is_load, mem_is_store, mem_pc_wr_en, dmem_ack;
  logic          pc_stall, if_stall, id_stall, ex_stall;
  logic          if_flush, ex_flush, mem_flush, dmem_req, mem_timeout_err;
  logic [1:0]    state_o;
  logic [CW-1:0] load_use_cnt, mem_wait_cnt, br_flush_cnt;

  pipeline_hazard_ctrl #(.REG_NUM_W(RW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs(id_rs), .id_rt(id_rt),
    .ex_is_load(ex_is_load), .ex_rg_wr_en(ex_rg_wr_en), .ex_wr_rg(ex_wr_rg),
    .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
    .mem_pc_wr_en(mem_pc_wr_en), .dmem_ack(dmem_ack),
    .pc_stall(pc_stall), .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
    .if_flush(if_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .dmem_req(dmem_req), .mem_timeout_err(mem_timeout_err), .state_o(state_o),
    .load_use_cnt(load_use_cnt), .mem_wait_cnt(mem_wait_cnt), .br_flush_cnt(br_flush_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic          idv;
    logic          urs;
    logic          urt;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          exld;
    logic          exwr;
    logic [RW-1:0] wrg;
    logic          mld;
    logic          mst;
    logic          br;
    logic          ack;
  } vin_t;

  typedef struct {
    vin_t          vin;
    logic [W-1:0]  exp;
  } tvec_t;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model state
  bit m_wait, m_err;
  int m_cnt, m_lu, m_br, m_mw;

  function automatic vin_t vi(input logic idv, urs, urt, input logic [RW-1:0] rs, rt,
                              input logic exld, exwr, input logic [RW-1:0] wrg,
                              input logic mld, mst, br, ack);
    vin_t v;
    v.idv = idv; v.urs = urs; v.urt = urt; v.rs = rs; v.rt = rt;
    v.exld = exld; v.exwr = exwr; v.wrg = wrg;
    v.mld = mld; v.mst = mst; v.br = br; v.ack = ack;
    return v;
  endfunction

  // {pc,if,id,ex stalls} {if,ex,mem flushes} req err state
  function automatic logic [W-1:0] mk(input logic [3:0] st, input logic [2:0] fl,
                                      input logic rq, input logic er, input logic [1:0] s);
    return {st, fl, rq, er, s};
  endfunction

  function automatic logic [W-1:0] pack_out();
    return {pc_stall, if_stall, id_stall, ex_stall, if_flush, ex_flush, mem_flush,
            dmem_req, mem_timeout_err, state_o};
  endfunction

  task automatic check(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic bit haz_of(input vin_t v);
    return v.idv && v.exld && v.exwr && (v.wrg != 0) &&
           ((v.urs && v.rs == v.wrg) || (v.urt && v.rt == v.wrg));
  endfunction

  // Expected outputs for this cycle, from the controller rules.
  function automatic logic [W-1:0] model_out(input vin_t v);
    bit acc;
    acc = v.mld || v.mst;
    if (m_err)               return mk(4'hF, 3'b000, 1'b0, 1'b1, 2'd2);
    if (m_wait)              return mk({4{!v.ack}}, 3'b000, 1'b1, 1'b0, 2'd1);
    if (acc && !v.ack)       return mk(4'hF, 3'b000, 1'b1, 1'b0, 2'd0);
    if (v.br)                return mk(4'h0, 3'b111, acc, 1'b0, 2'd0);
    if (haz_of(v))           return mk(4'b1100, 3'b010, acc, 1'b0, 2'd0);
    return mk(4'h0, 3'b000, acc, 1'b0, 2'd0);
  endfunction

  task automatic model_step(input vin_t v);
    if (m_err) return;
    if (m_wait) begin
      if (v.ack) m_wait = 0;
      else begin
        m_mw++;
        if (m_cnt == TO) begin m_err = 1; m_wait = 0; end
        else m_cnt++;
      end
    end else if ((v.mld || v.mst) && !v.ack) begin
      m_wait = 1; m_cnt = 1;
    end else if (v.br) m_br++;
    else if (haz_of(v)) m_lu++;
  endtask

  task automatic model_reset();
    m_wait = 0; m_err = 0; m_cnt = 0; m_lu = 0; m_br = 0; m_mw = 0;
  endtask

  // driver
  task automatic apply(input vin_t v);
    id_valid = v.idv; id_uses_rs = v.urs; id_uses_rt = v.urt;
    id_rs = v.rs; id_rt = v.rt;
    ex_is_load = v.exld; ex_rg_wr_en = v.exwr; ex_wr_rg = v.wrg;
    mem_is_load = v.mld; mem_is_store = v.mst; mem_pc_wr_en = v.br; dmem_ack = v.ack;
  endtask

  // One cycle: drive, compare at negedge, advance model, step past posedge.
  task automatic run_cycle(input vin_t v, input logic [W-1:0] exp, input string nm);
    apply(v);
    exp_q.push_back(exp);
    @(negedge clk);
    check(nm, {21'd0, pack_out()}, {21'd0, exp_q.pop_front()});
    model_step(v);
    @(posedge clk); #1;
  endtask

  task automatic check_counters(input string nm);
    logic [CW-1:0] e_lu, e_mw, e_br;
`ifdef PIPE_HAZ_PERF_CNT_EN
    e_lu = CW'(m_lu); e_mw = CW'(m_mw); e_br = CW'(m_br);
`else
    e_lu = '0; e_mw = '0; e_br = '0;
`endif
    check({nm, "_load_use_cnt"}, load_use_cnt, e_lu);
    check({nm, "_mem_wait_cnt"}, mem_wait_cnt, e_mw);
    check({nm, "_br_flush_cnt"}, br_flush_cnt, e_br);
  endtask

  tvec_t tbl[13];
  vin_t  idle, v;
  vin_t  ld_wait, ld_ack;

  initial begin
    idle    = vi(0,0,0, 5'd0,5'd0, 0,0,5'd0, 0,0,0,0);
    ld_wait = vi(0,0,0, 5'd0,5'd0, 0,0,5'd0, 1,0,0,0);
    ld_ack  = vi(0,0,0, 5'd0,5'd0, 0,0,5'd0, 1,0,0,1);

    // single-cycle vectors, all evaluated in RUN
    tbl[0]  = '{vi(0,0,0, 5'd0,5'd0, 0,0,5'd0, 0,0,0,0), mk(4'h0, 3'b000, 0, 0, 0)};
    tbl[1]  = '{vi(1,0,1, 5'd0,5'd5, 1,1,5'd5, 0,0,0,0), mk(4'b1100, 3'b010, 0, 0, 0)};
    tbl[2]  = '{vi(1,0,1, 5'd0,5'd0, 1,1,5'd0, 0,0,0,0), mk(4'h0, 3'b000, 0, 0, 0)};
    tbl[3]  = '{vi(1,1,0, 5'd7,5'd0, 1,1,5'd7, 0,0,0,0), mk(4'b1100, 3'b010, 0, 0, 0)};
    tbl[4]  = '{vi(1,0,0, 5'd7,5'd7, 1,1,5'd7, 0,0,0,0), mk(4'h0, 3'b000, 0, 0, 0)};
    tbl[5]  = '{vi(1,1,1, 5'd3,5'd3, 0,1,5'd3, 0,0,0,0), mk(4'h0, 3'b000, 0, 0, 0)};
    tbl[6]  = '{vi(1,1,1, 5'd3,5'd3, 1,0,5'd3, 0,0,0,0), mk(4'h0, 3'b000, 0, 0, 0)};
    tbl[7]  = '{vi(0,1,1, 5'd3,5'd3, 1,1,5'd3, 0,0,0,0), mk(4'h0, 3'b000, 0, 0, 0)};
    tbl[8]  = '{vi(0,0,0, 5'd0,5'd0, 0,0,5'd0, 0,1,0,1), mk(4'h0, 3'b000, 1, 0, 0)};
    tbl[9]  = '{vi(1,0,1, 5'd0,5'd5, 1,1,5'd5, 0,0,1,0), mk(4'h0, 3'b111, 0, 0, 0)};
    tbl[10] = '{vi(0,0,0, 5'd0,5'd0, 0,0,5'd0, 0,0,1,0), mk(4'h0, 3'b111, 0, 0, 0)};
    tbl[11] = '{vi(0,0,0, 5'd0,5'd0, 0,0,5'd0, 1,0,1,1), mk(4'h0, 3'b111, 1, 0, 0)};
    tbl[12] = '{vi(1,1,0, 5'd9,5'd0, 1,1,5'd9, 1,0,0,1), mk(4'b1100, 3'b010, 1, 0, 0)};

    // reset
    rst = 1'b1;
    apply(idle);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {21'd0, pack_out()}, {21'd0, mk(4'h0, 3'b000, 0, 0, 0)});
    check_counters("rst");
    rst = 1'b0;

    // table
    for (int i = 0; i < 13; i++) run_cycle(tbl[i].vin, tbl[i].exp, $sformatf("tbl%0d", i));

    // 3-cycle load: ack on the 4th cycle; branch + hazard during the wait are ignored
    run_cycle(ld_wait, mk(4'hF, 3'b000, 1, 0, 0), "ld3_c1");
    run_cycle(vi(1,0,1, 5'd0,5'd5, 1,1,5'd5, 1,0,1,0), mk(4'hF, 3'b000, 1, 0, 1), "ld3_c2");
    run_cycle(ld_wait, mk(4'hF, 3'b000, 1, 0, 1), "ld3_c3");
    run_cycle(ld_ack,  mk(4'h0, 3'b000, 1, 0, 1), "ld3_ack");
    run_cycle(idle,    mk(4'h0, 3'b000, 0, 0, 0), "ld3_run");

    // timeout: 5 MEM-stalled cycles then ERR
    run_cycle(ld_wait, mk(4'hF, 3'b000, 1, 0, 0), "to_c1");
    for (int i = 2; i <= 5; i++)
      run_cycle(ld_wait, mk(4'hF, 3'b000, 1, 0, 1), $sformatf("to_c%0d", i));
    run_cycle(ld_wait, mk(4'hF, 3'b000, 0, 1, 2), "to_err");
    run_cycle(ld_ack,  mk(4'hF, 3'b000, 0, 1, 2), "to_err_ack");
    rst = 1'b1;
    apply(idle);
    @(negedge clk);
    check("to_rst_stalls", {28'd0, pc_stall, if_stall, id_stall, ex_stall}, 32'd0);
    check("to_rst_req", {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    run_cycle(idle, mk(4'h0, 3'b000, 0, 0, 0), "to_after_rst");

    // perf: 2 load-use, 1 branch, one load with 3 stalled MEM_WAIT cycles
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    model_reset();
    run_cycle(tbl[1].vin, tbl[1].exp, "perf_lu1");
    run_cycle(idle, mk(4'h0, 3'b000, 0, 0, 0), "perf_gap");
    run_cycle(tbl[3].vin, tbl[3].exp, "perf_lu2");
    run_cycle(tbl[10].vin, tbl[10].exp, "perf_br");
    run_cycle(ld_wait, mk(4'hF, 3'b000, 1, 0, 0), "perf_ld_c1");
    for (int i = 0; i < 3; i++) run_cycle(ld_wait, mk(4'hF, 3'b000, 1, 0, 1), "perf_ld_w");
    run_cycle(ld_ack, mk(4'h0, 3'b000, 1, 0, 1), "perf_ld_ack");
`ifdef PIPE_HAZ_PERF_CNT_EN
    check("perf_lu_fixed", load_use_cnt, 32'd2);
    check("perf_br_fixed", br_flush_cnt, 32'd1);
    check("perf_mw_fixed", mem_wait_cnt, 32'd3);
`else
    check_counters("perf_off");
`endif

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      v.idv  = ($urandom_range(0, 3) != 0);
      v.urs  = 1'($urandom_range(0, 1));
      v.urt  = 1'($urandom_range(0, 1));
      v.rs   = RW'($urandom_range(0, 3));
      v.rt   = RW'($urandom_range(0, 3));
      v.exld = 1'($urandom_range(0, 1));
      v.exwr = ($urandom_range(0, 3) != 0);
      v.wrg  = RW'($urandom_range(0, 3));
      v.mld  = ($urandom_range(0, 4) == 0);
      v.mst  = ($urandom_range(0, 5) == 0);
      v.br   = ($urandom_range(0, 5) == 0);
      v.ack  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        apply(v);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
      end else begin
        run_cycle(v, model_out(v), "rand");
      end
    end
    check_counters("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
